cpc_mem_arbiter: RTL and testbench
==================================

// Module: cpc_mem_arbiter
// PURPOSE
//  Shares the single external memory port between the CPU and the gate-array video fetch.
//  Video reads are 16-bit words; CPU accesses are bytes.
//  Sits between the motherboard (CPU/MMU bus, vram fetch) and the SDRAM controller.
//  Sequences one access at a time, stalls the CPU through cpu_wait, and bounds video hogging.
// PARAMETERS
//  ADDR_W      23      byte address width of the memory port
//  VID_BASE    23'h0   byte base address of the video window
//  MAX_VID     3       consecutive video grants allowed while the CPU is pending (1..7)
//  TIMEOUT     63      cycles to wait for mem_ack before aborting (1..255)
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous active-low reset
//  vid_req     in   1       video word read request, level, held until vid_ack
//  vid_addr    in   15      video word address; byte addr = VID_BASE + {vid_addr,1'b0}
//  vid_data    out  16      video read data, valid in the vid_ack cycle and held after
//  vid_ack     out  1       one-cycle completion pulse for video
//  cpu_rd      in   1       CPU byte read request, level, held until cpu_ack
//  cpu_wr      in   1       CPU byte write request, level, held until cpu_ack
//  cpu_addr    in   ADDR_W  CPU byte address (from MMU)
//  cpu_wdata   in   8       CPU write data
//  cpu_rdata   out  8       CPU read byte, valid in the cpu_ack cycle and held after
//  cpu_ack     out  1       one-cycle completion pulse for the CPU
//  cpu_wait    out  1       combinational: (cpu_rd|cpu_wr) & ~cpu_ack
//  mem_req     out  1       memory request, held until mem_ack
//  mem_we      out  1       1 = byte write, 0 = word read
//  mem_addr    out  ADDR_W  memory byte address; bit 0 = 0 for video reads
//  mem_wdata   out  8       memory write byte
//  mem_ack     in   1       memory completion; mem_rdata is valid in the same cycle
//  mem_rdata   in   16      memory word; byte 0 = [7:0]
//  err_timeout out  1       sticky; set on any aborted access, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, streak counter 0, timer 0. Async assertion drops mem_req immediately.
//  States:
//   IDLE:
//    - Requests are sampled here only.
//    - The first grant is issued in the cycle the request is seen.
//    - mem_req, mem_we, mem_addr and mem_wdata are registered at grant and stay stable until exit.
//   V_ACC: mem_req=1, mem_we=0, mem_addr=video address.
//   C_ACC: mem_req=1, mem_we=cpu_wr, mem_addr=cpu_addr.
//   DONE:
//    - Exactly one cycle; mem_req=0.
//    - The matching ack is pulsed; vid_data or cpu_rdata is updated.
//    - Always returns to IDLE.
//  Transitions: V_ACC/C_ACC -> DONE on mem_ack, or when the timer reaches TIMEOUT.
//  Grant rule in IDLE:
//   - CPU is granted if it is pending and (no video request, or streak == MAX_VID).
//   - Otherwise video is granted if vid_req.
//  cpu_rd & cpu_wr both high: treated as a write.
//  Streak counter (3 bits, saturating at MAX_VID):
//   - +1 on each video grant.
//   - Cleared on a CPU grant.
//   - Cleared in any IDLE cycle without vid_req.
//  Timer (8 bits): cleared at grant, +1 per cycle in the ACC states.
//  Abort (timer == TIMEOUT without mem_ack):
//   - mem_req drops; go to DONE.
//   - Data returned = 16'hFFFF for video, 8'hFF for a CPU read.
//   - err_timeout is set to 1.
//  mem_ack arriving in the same cycle as the timeout: mem_ack wins; no error.
//  CPU read byte = cpu_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0].
//  mem_ack outside the ACC states is ignored.
//  Latency: request seen in IDLE at cycle 0, mem_ack at cycle N (N>=1) -> ack pulse at cycle N+1.
//   Minimum 2 cycles per access; back-to-back service period = N+2 cycles.
//  Requesters must drop the request in the cycle after the ack.
//   A request still high in IDLE after its ack is treated as a new access.
//  Video address arithmetic is modulo 2^ADDR_W (wraps silently).
// TESTING
//  1 CPU read:
//    cpu_rd=1, cpu_addr=23'h4001, mem_rdata=16'hA55A with mem_ack at cycle 3
//    -> mem_addr=23'h4001, mem_we=0; cpu_ack at cycle 4 with cpu_rdata=8'hA5;
//       cpu_wait high for cycles 0..3.
//  2 Video read:
//    vid_req=1, vid_addr=15'h0010, VID_BASE=23'h40000
//    -> mem_addr=23'h40020, vid_data=mem_rdata at ack, vid_ack width exactly 1 cycle.
//  3 Contention:
//    vid_req and cpu_wr held continuously, MAX_VID=3, mem_ack 1 cycle after each req
//    -> grant order V,V,V,C,V,V,V,C...; the CPU write carries cpu_wdata on mem_wdata with mem_we=1.
//  4 Timeout:
//    TIMEOUT=4, cpu_rd=1, mem_ack never
//    -> mem_req high for exactly 4 cycles, cpu_ack with cpu_rdata=8'hFF, err_timeout=1 until reset.
//  5 Reset mid-access:
//    assert reset_n=0 during C_ACC
//    -> mem_req, cpu_ack and err_timeout go 0 asynchronously;
//       after release the next request is granted from IDLE normally.
//  6 Write+read conflict:
//    cpu_rd=cpu_wr=1 -> single access with mem_we=1; no second access issued.

Source files
------------

// File: rtl/cpc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cpc_mem_arbiter
//
// Shares the single external memory port between the CPU (byte accesses
// through the MMU) and the gate-array video fetch (16-bit word reads).
// Only one access is in flight at a time. The CPU is stalled through
// cpu_wait until its access completes. Video is allowed at most MAX_VID
// consecutive grants while the CPU is pending, so the CPU cannot be starved.
//
// Parameters
//   ADDR_W    byte address width of the memory port
//   VID_BASE  byte base address of the video window
//   MAX_VID   consecutive video grants allowed while the CPU waits (1..7)
//   TIMEOUT   cycles to wait for mem_ack before aborting (1..255)
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   vid_req/vid_addr       video word read request (level) and word address
//   vid_data/vid_ack       video read word and one-cycle completion pulse
//   cpu_rd/cpu_wr          CPU byte read / write request (level)
//   cpu_addr/cpu_wdata     CPU byte address and write byte
//   cpu_rdata/cpu_ack      CPU read byte and one-cycle completion pulse
//   cpu_wait               CPU stall, combinational
//   mem_req/mem_we         memory request (held until mem_ack) and write enable
//   mem_addr/mem_wdata     memory byte address and write byte
//   mem_ack/mem_rdata      memory completion and read word
//   err_timeout            sticky flag for any aborted access
// ----------------------------------------------------------------------------
module cpc_mem_arbiter #(
   parameter int                ADDR_W   = 23,
   parameter logic [ADDR_W-1:0] VID_BASE = '0,
   parameter int                MAX_VID  = 3,
   parameter int                TIMEOUT  = 63
) (
   input  logic              clk,
   input  logic              reset_n,
   // video fetch side
   input  logic              vid_req,
   input  logic [14:0]       vid_addr,
   output logic [15:0]       vid_data,
   output logic              vid_ack,
   // CPU side
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_wait,
   // memory controller side
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   // status
   output logic              err_timeout
);

   localparam logic [2:0] STREAK_MAX = 3'(MAX_VID);
   // The abort decision is taken in the cycle whose timer increment would
   // make it reach TIMEOUT, so mem_req is high for exactly TIMEOUT cycles.
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      V_ACC = 2'd1,
      C_ACC = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   logic [2:0]  streak;
   logic [7:0]  timer;

   logic        cpu_pend;
   logic        grant_cpu;
   logic        grant_vid;

   // Saturating increment of the video streak counter.
   function automatic logic [2:0] streak_inc(input logic [2:0] s);
      if (s >= STREAK_MAX) begin
         return STREAK_MAX;
      end
      return s + 3'd1;
   endfunction

   // Video word address to memory byte address; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] vid_byte_addr(input logic [14:0] wa);
      return VID_BASE + ADDR_W'({wa, 1'b0});
   endfunction

   // Byte lane select for a CPU read.
   function automatic logic [7:0] cpu_byte(input logic odd, input logic [15:0] w);
      return odd ? w[15:8] : w[7:0];
   endfunction

   assign cpu_pend  = cpu_rd | cpu_wr;
   assign cpu_wait  = cpu_pend & ~cpu_ack;

   // Video wins unless the CPU has waited through a full streak of
   // video grants, or video is not asking at all.
   assign grant_cpu = cpu_pend & (~vid_req | (streak == STREAK_MAX));
   assign grant_vid = vid_req & ~grant_cpu;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         streak      <= 3'd0;
         timer       <= 8'd0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 8'd0;
         vid_data    <= 16'd0;
         vid_ack     <= 1'b0;
         cpu_rdata   <= 8'd0;
         cpu_ack     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         vid_ack <= 1'b0;
         cpu_ack <= 1'b0;

         unique case (state)
            IDLE: begin
               timer <= 8'd0;
               if (grant_cpu) begin
                  state     <= C_ACC;
                  streak    <= 3'd0;
                  mem_req   <= 1'b1;
                  // a simultaneous read and write is serviced as a write
                  mem_we    <= cpu_wr;
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
               end else if (grant_vid) begin
                  state    <= V_ACC;
                  streak   <= streak_inc(streak);
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= vid_byte_addr(vid_addr);
               end else if (!vid_req) begin
                  streak <= 3'd0;
               end
            end

            V_ACC: begin
               if (mem_ack) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  vid_ack  <= 1'b1;
                  vid_data <= mem_rdata;
               end else if (timer == TMO_LAST) begin
                  state       <= DONE;
                  mem_req     <= 1'b0;
                  vid_ack     <= 1'b1;
                  vid_data    <= 16'hFFFF;
                  err_timeout <= 1'b1;
               end else begin
                  timer <= timer + 8'd1;
               end
            end

            C_ACC: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  cpu_ack <= 1'b1;
                  // mem_addr still holds cpu_addr, so bit 0 picks the lane
                  if (!mem_we) begin
                     cpu_rdata <= cpu_byte(mem_addr[0], mem_rdata);
                  end
               end else if (timer == TMO_LAST) begin
                  state       <= DONE;
                  mem_req     <= 1'b0;
                  cpu_ack     <= 1'b1;
                  err_timeout <= 1'b1;
                  if (!mem_we) begin
                     cpu_rdata <= 8'hFF;
                  end
               end else begin
                  timer <= timer + 8'd1;
               end
            end

            DONE: begin
               // the ack pulse is visible during this single cycle
               state  <= IDLE;
               mem_we <= 1'b0;
            end

            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpc_mem_arbiter
//
// Directed bench for cpc_mem_arbiter. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge. "Cycle 0" is the
// cycle in which a request is first presented to the arbiter in IDLE.
// ----------------------------------------------------------------------------
module tb_cpc_mem_arbiter;

   localparam int ADDR_W = 23;

   logic              clk;
   logic              reset_n;
   logic              vid_req;
   logic [14:0]       vid_addr;
   logic [15:0]       vid_data;
   logic              vid_ack;
   logic              cpu_rd;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;
   logic              cpu_wait;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   logic [15:0]       mem_rdata;
   logic              err_timeout;

   int n_checks = 0;
   int n_errors = 0;

   cpc_mem_arbiter #(
      .ADDR_W   (ADDR_W),
      .VID_BASE (23'h40000),
      .MAX_VID  (3),
      .TIMEOUT  (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .vid_req     (vid_req),
      .vid_addr    (vid_addr),
      .vid_data    (vid_data),
      .vid_ack     (vid_ack),
      .cpu_rd      (cpu_rd),
      .cpu_wr      (cpu_wr),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ack     (cpu_ack),
      .cpu_wait    (cpu_wait),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      int req_cnt;
      int ack_cnt;
      int ack_cyc;
      logic [7:0] rb;
      int gcnt;
      int gseq [8];
      int grise [8];
      logic prev_req;

      reset_n   = 1'b0;
      vid_req   = 1'b0;
      vid_addr  = '0;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      smp();
      check("rst_mem_req", mem_req, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_vid_ack", vid_ack, 0);
      check("rst_err", err_timeout, 0);
      check("rst_cpu_wait", cpu_wait, 0);
      check("rst_vid_data", vid_data, 0);
      reset_n = 1'b1;

      // ---------------- CPU read, ack at cycle 3 ----------------
      tick();
      cpu_rd = 1'b1; cpu_addr = 23'h4001; mem_rdata = 16'hA55A;
      smp();
      check("t1_wait_c0", cpu_wait, 1);
      check("t1_req_c0", mem_req, 0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         mem_ack = (c == 3);
         if (c == 5) cpu_rd = 1'b0;
         smp();
         if (c <= 3) begin
            check($sformatf("t1_wait_c%0d", c), cpu_wait, 1);
            check($sformatf("t1_ack_c%0d", c), cpu_ack, 0);
         end
         if (c == 1) begin
            check("t1_req_c1", mem_req, 1);
            check("t1_addr", mem_addr, 23'h4001);
            check("t1_we", mem_we, 0);
         end
         if (c == 4) begin
            check("t1_ack_c4", cpu_ack, 1);
            check("t1_rdata", cpu_rdata, 8'hA5);
            check("t1_wait_c4", cpu_wait, 0);
            check("t1_req_c4", mem_req, 0);
         end
         if (c == 5) begin
            check("t1_ack_c5", cpu_ack, 0);
            check("t1_rdata_held", cpu_rdata, 8'hA5);
         end
      end
      tick();
      smp();
      check("t1_no_reissue", mem_req, 0);

      // ---------------- video read ----------------
      tick();
      vid_req = 1'b1; vid_addr = 15'h0010;
      ack_cnt = 0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         mem_ack   = (c == 2);
         mem_rdata = (c == 2) ? 16'hBEEF : 16'h0000;
         if (c == 4) vid_req = 1'b0;
         smp();
         ack_cnt += int'(vid_ack);
         if (c == 1) begin
            check("t2_req", mem_req, 1);
            check("t2_addr", mem_addr, 23'h40020);
            check("t2_we", mem_we, 0);
         end
         if (c == 3) begin
            check("t2_ack_c3", vid_ack, 1);
            check("t2_data", vid_data, 16'hBEEF);
         end
         if (c == 4) check("t2_data_held", vid_data, 16'hBEEF);
      end
      check("t2_ack_width", ack_cnt, 1);

      // ---------------- contention V,V,V,C ----------------
      tick();
      vid_req = 1'b1; vid_addr = 15'h0100;
      cpu_wr = 1'b1; cpu_addr = 23'h01234; cpu_wdata = 8'h3C;
      gcnt = 0;
      prev_req = 1'b0;
      for (int c = 1; c < 60 && gcnt < 8; c++) begin
         tick();
         mem_ack   = mem_req;
         mem_rdata = 16'h0F0F;
         smp();
         if (mem_req && !prev_req) begin
            gseq[gcnt]  = int'(mem_we);
            grise[gcnt] = c;
            if (mem_we) begin
               check("t3_cpu_wdata", mem_wdata, 8'h3C);
               check("t3_cpu_addr", mem_addr, 23'h01234);
            end else begin
               check("t3_vid_addr", mem_addr, 23'h40200);
            end
            gcnt++;
         end
         prev_req = mem_req;
      end
      check("t3_grant_count", gcnt, 8);
      for (int i = 0; i < gcnt; i++) begin
         check($sformatf("t3_grant%0d_is_cpu", i), gseq[i], (i % 4 == 3) ? 1 : 0);
      end
      if (gcnt >= 2) check("t3_period", grise[1] - grise[0], 3);
      repeat (5) begin
         tick();
         vid_req = 1'b0; cpu_wr = 1'b0;
         mem_ack = mem_req;
      end
      mem_ack = 1'b0;
      smp();
      check("t3_drained", mem_req, 0);

      // ---------------- mem_ack on the timeout cycle ----------------
      tick();
      cpu_rd = 1'b1; cpu_addr = 23'h0002;
      for (int c = 1; c <= 6; c++) begin
         tick();
         mem_ack   = (c == 4);
         mem_rdata = 16'h1234;
         if (c == 6) cpu_rd = 1'b0;
         smp();
         if (c == 4) check("tb_req_c4", mem_req, 1);
         if (c == 5) begin
            check("tb_ack", cpu_ack, 1);
            check("tb_rdata", cpu_rdata, 8'h34);
            check("tb_no_err", err_timeout, 0);
         end
      end

      // ---------------- read + write together ----------------
      tick();
      cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 23'h0007; cpu_wdata = 8'h5A;
      req_cnt = 0; ack_cnt = 0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         mem_ack = mem_req;
         if (c == 3) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
         smp();
         req_cnt += int'(mem_req);
         ack_cnt += int'(cpu_ack);
         if (c == 1) begin
            check("t6_we", mem_we, 1);
            check("t6_wdata", mem_wdata, 8'h5A);
         end
      end
      mem_ack = 1'b0;
      check("t6_one_access", req_cnt, 1);
      check("t6_one_ack", ack_cnt, 1);
      check("t6_rdata_unchanged", cpu_rdata, 8'h34);

      // ---------------- timeout ----------------
      tick();
      cpu_rd = 1'b1; cpu_addr = 23'h0100;
      req_cnt = 0; ack_cyc = -1; rb = 8'h00;
      for (int c = 1; c <= 7; c++) begin
         tick();
         mem_ack = 1'b0;
         if (c == 6) cpu_rd = 1'b0;
         smp();
         req_cnt += int'(mem_req);
         if (cpu_ack) begin ack_cyc = c; rb = cpu_rdata; end
         if (c == 3) check("t4_err_before", err_timeout, 0);
      end
      check("t4_req_cycles", req_cnt, 4);
      check("t4_ack_cycle", ack_cyc, 5);
      check("t4_rdata_ff", rb, 8'hFF);
      check("t4_err_set", err_timeout, 1);
      repeat (3) tick();
      smp();
      check("t4_err_sticky", err_timeout, 1);

      // ---------------- reset in the middle of a CPU access ----------------
      tick();
      cpu_wr = 1'b1; cpu_addr = 23'h0055; cpu_wdata = 8'h11;
      tick();
      smp();
      check("t5_req_before", mem_req, 1);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("t5_async_req", mem_req, 0);
      check("t5_async_ack", cpu_ack, 0);
      check("t5_async_err", err_timeout, 0);
      cpu_wr = 1'b0;
      @(posedge clk);
      smp();
      reset_n = 1'b1;
      tick();
      cpu_rd = 1'b1; cpu_addr = 23'h0003;
      tick();
      mem_ack = mem_req; mem_rdata = 16'h7700;
      smp();
      check("t5_new_req", mem_req, 1);
      check("t5_new_addr", mem_addr, 23'h0003);
      tick();
      mem_ack = 1'b0;
      smp();
      check("t5_new_ack", cpu_ack, 1);
      check("t5_new_rdata", cpu_rdata, 8'h77);
      check("t5_new_err", err_timeout, 0);
      tick();
      cpu_rd = 1'b0;
      smp();
      check("t5_ack_drop", cpu_ack, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
